lif_array: RTL

- Parametrised multi-channel leaky integrate-and-fire (LIF) neuron array.
- Successor to the single-neuron LIF core; sits behind the TinyTapeout top wrapper.
- Each channel integrates an unsigned input current and leaks by a shift-based decay.
- Each channel fires a one-cycle spike at a runtime threshold, then enters a refractory period.
- An internal prescaler sets the timestep rate.

---
 rtl/lif_array.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lif_array.sv
// lif_array: parametrised multi-channel leaky integrate-and-fire neuron array.
// Each channel integrates an unsigned current, leaks by a right shift, fires a
// one-cycle spike when the membrane reaches the shared threshold and then sits
// out a refractory period. A prescaler sets how often a timestep happens.
// Optional per-channel 8-bit saturating spike counters are built only when the
// macro LIF_ARRAY_SPIKE_COUNT_EN is defined; otherwise spike_cnt is tied to 0.

module lif_array #(
    parameter int CHANNELS      = 4,
    parameter int WIDTH         = 8,
    parameter int LEAK_SHIFT    = 1,
    parameter int REFRAC_CYCLES = 3,
    parameter int RESET_MODE    = 0,
    parameter int TICK_DIV      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [WIDTH-1:0]          threshold,
    input  logic [CHANNELS*WIDTH-1:0] current,
    output logic [CHANNELS-1:0]       spike,
    output logic [CHANNELS*WIDTH-1:0] state,
    output logic                      tick,
    output logic [CHANNELS*8-1:0]     spike_cnt
);

    // Counter and refractory widths never drop below one bit so that the
    // degenerate TICK_DIV=1 and REFRAC_CYCLES=0 builds still elaborate.
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RC_W  = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(REFRAC_CYCLES);
    localparam logic [WIDTH:0]   SAT      = {1'b0, {WIDTH{1'b1}}};

    logic [CNT_W-1:0] cnt;
    logic             tick_now;

    assign tick_now = en && (cnt == CNT_LAST);

    // Prescaler: counts enabled cycles and wraps after the last one, freezing while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            if (tick_now) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Timestep strobe: registered so it lines up with the updated state and spikes.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= tick_now;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] st;
        logic [WIDTH-1:0] leaked;
        logic [WIDTH:0]   raw_sum;
        logic [WIDTH:0]   sum;
        logic [RC_W-1:0]  rc;
        logic [WIDTH-1:0] st_next;
        logic [RC_W-1:0]  rc_next;
        logic             fire;
        logic             spk;

        assign cur     = current[g*WIDTH +: WIDTH];
        assign leaked  = st - (st >> LEAK_SHIFT);
        assign raw_sum = {1'b0, leaked} + {1'b0, cur};
        assign sum     = (raw_sum > SAT) ? SAT : raw_sum;

        // Next-step neuron rule: refractory hold/clear, otherwise leak, integrate and compare.
        always_comb begin
            st_next = st;
            rc_next = rc;
            fire    = 1'b0;
            if (rc != '0) begin
                rc_next = rc - RC_W'(1);
                if (RESET_MODE == 0) begin
                    st_next = '0;
                end
            end else if (sum >= {1'b0, threshold}) begin
                fire    = 1'b1;
                rc_next = RC_LOAD;
                if (RESET_MODE == 0) begin
                    st_next = '0;
                end else begin
                    st_next = WIDTH'(sum - {1'b0, threshold});
                end
            end else begin
                st_next = sum[WIDTH-1:0];
            end
        end

        // Channel registers: commit the step only on a timestep, spike is a one-cycle pulse.
        always_ff @(posedge clk) begin
            if (rst) begin
                st  <= '0;
                rc  <= '0;
                spk <= 1'b0;
            end else if (tick_now) begin
                st  <= st_next;
                rc  <= rc_next;
                spk <= fire;
            end else begin
                spk <= 1'b0;
            end
        end

        assign spike[g]                  = spk;
        assign state[g*WIDTH +: WIDTH]   = st;

`ifdef LIF_ARRAY_SPIKE_COUNT_EN
        logic [7:0] sc;

        // Spike counter: counts each visible spike pulse and sticks at 255 until reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                sc <= 8'd0;
            end else if (spk && (sc != 8'hFF)) begin
                sc <= sc + 8'd1;
            end
        end

        assign spike_cnt[g*8 +: 8] = sc;
`else
        assign spike_cnt[g*8 +: 8] = 8'd0;
`endif
    end

endmodule
